buffer_access_arbiter: RTL and testbench

Single-cycle access arbiter for the endpoint's shared single-port data buffer. Three requesters share the buffer: the USB RX path (push), the USB TX path (pop) and the AHB-lite slave (register-mapped read/write). The block grants at most one requester per cycle and drives the buffer's read/write strobes and owner select. It stalls the AHB side through `hready`, and a starvation guard bounds how long AHB can be held off by USB traffic.

---
 rtl/buffer_access_arbiter.sv | 126 ++++++++++++
 tb/tb_buffer_access_arbiter.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/buffer_access_arbiter.sv
// Single-cycle arbiter for the endpoint's shared single-port data buffer.
// Arbitrates USB RX push, USB TX pop and AHB access, with a starvation guard for AHB.
module buffer_access_arbiter #(
    parameter int MAX_WAIT = 4
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       buf_clear_req,
    input  logic       rx_req,
    input  logic       tx_req,
    input  logic       ahb_req,
    input  logic       ahb_write,
    output logic       rx_grant,
    output logic       tx_grant,
    output logic       ahb_grant,
    output logic       buf_clear,
    output logic       buf_we,
    output logic       buf_re,
    output logic [1:0] buf_sel,
    output logic       hready
);

    localparam int CW = $clog2(MAX_WAIT + 1);
    localparam logic [CW-1:0] WAIT_MAX = CW'(MAX_WAIT);

    typedef enum logic [2:0] {IDLE, CLEAR, GNT_RX, GNT_TX, GNT_AHB} state_t;
    typedef enum logic {USB_TX, USB_RX} usb_t;

    state_t        state, next_state;
    usb_t          last_usb;
    logic [CW-1:0] wait_cnt;
    logic          ahb_wr_q;
    logic          e_rx, e_tx, e_ahb;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // The currently granted requester is masked, so nobody gets back-to-back grants.
    assign e_rx  = rx_req  && (state != GNT_RX);
    assign e_tx  = tx_req  && (state != GNT_TX);
    assign e_ahb = ahb_req && (state != GNT_AHB);

    always_comb begin
        // NOTE: default first so every path assigns next_state and no latch is inferred.
        next_state = IDLE;
        if (buf_clear_req && (state != CLEAR)) begin
            next_state = CLEAR;
        end else if (e_ahb && (wait_cnt == WAIT_MAX)) begin
            next_state = GNT_AHB;
        end else if (e_rx && e_tx) begin
            next_state = (last_usb == USB_TX) ? GNT_RX : GNT_TX;
        end else if (e_rx) begin
            next_state = GNT_RX;
        end else if (e_tx) begin
            next_state = GNT_TX;
        end else if (e_ahb) begin
            next_state = GNT_AHB;
        end
    end

    // Starvation counter, fairness flag and captured AHB direction.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wait_cnt <= '0;
            last_usb <= USB_TX;
            ahb_wr_q <= 1'b0;
        end else begin
            if (!ahb_req || ahb_grant) begin
                wait_cnt <= '0;
            end else if (wait_cnt != WAIT_MAX) begin
                wait_cnt <= wait_cnt + CW'(1);
            end
            if (next_state == GNT_RX) begin
                last_usb <= USB_RX;
            end else if (next_state == GNT_TX) begin
                last_usb <= USB_TX;
            end
            if (next_state == GNT_AHB) begin
                ahb_wr_q <= ahb_write;
            end
        end
    end

    always_comb begin
        rx_grant  = 1'b0;
        tx_grant  = 1'b0;
        ahb_grant = 1'b0;
        buf_clear = 1'b0;
        buf_we    = 1'b0;
        buf_re    = 1'b0;
        buf_sel   = 2'b00;
        case (state)
            CLEAR: begin
                buf_clear = 1'b1;
            end
            GNT_RX: begin
                rx_grant = 1'b1;
                buf_we   = 1'b1;
                buf_sel  = 2'b01;
            end
            GNT_TX: begin
                tx_grant = 1'b1;
                buf_re   = 1'b1;
                buf_sel  = 2'b10;
            end
            GNT_AHB: begin
                ahb_grant = 1'b1;
                buf_we    = ahb_wr_q;
                buf_re    = !ahb_wr_q;
                buf_sel   = 2'b11;
            end
            default: ;
        endcase
    end

    // Only combinational path through the block: AHB stalls until its grant cycle.
    assign hready = !ahb_req || ahb_grant;

endmodule

// File: tb/tb_buffer_access_arbiter.sv
// Self-checking bench for buffer_access_arbiter: directed scenarios plus
// randomized traffic compared cycle by cycle against a behavioural owner model.
module tb_buffer_access_arbiter;

    localparam int MAX_WAIT = 4;

    // Owner codes double as the buf_sel value for the three requesters.
    localparam int O_IDLE = 0, O_RX = 1, O_TX = 2, O_AHB = 3, O_CLR = 4;

    logic       clk = 1'b0;
    logic       n_rst;
    logic       buf_clear_req, rx_req, tx_req, ahb_req, ahb_write;
    logic       rx_grant, tx_grant, ahb_grant, buf_clear, buf_we, buf_re, hready;
    logic [1:0] buf_sel;

    int total = 0;
    int bad   = 0;

    // Reference model: who owns the buffer, how long AHB has been stalled,
    // whether RX was the last USB side served, and the captured AHB direction.
    int m_owner;
    int m_stall;
    bit m_rx_last;
    bit m_wr;

    buffer_access_arbiter #(.MAX_WAIT(MAX_WAIT)) dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .buf_clear_req(buf_clear_req),
        .rx_req       (rx_req),
        .tx_req       (tx_req),
        .ahb_req      (ahb_req),
        .ahb_write    (ahb_write),
        .rx_grant     (rx_grant),
        .tx_grant     (tx_grant),
        .ahb_grant    (ahb_grant),
        .buf_clear    (buf_clear),
        .buf_we       (buf_we),
        .buf_re       (buf_re),
        .buf_sel      (buf_sel),
        .hready       (hready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_owner   = O_IDLE;
        m_stall   = 0;
        m_rx_last = 1'b0;
        m_wr      = 1'b0;
    endtask

    // Advance the model by one clock using the inputs currently driven.
    task automatic model_step();
        bit e_rx, e_tx, e_ahb;
        int nxt;
        e_rx  = rx_req  && m_owner != O_RX;
        e_tx  = tx_req  && m_owner != O_TX;
        e_ahb = ahb_req && m_owner != O_AHB;
        if (buf_clear_req && m_owner != O_CLR)   nxt = O_CLR;
        else if (e_ahb && m_stall == MAX_WAIT)   nxt = O_AHB;
        else if (e_rx && e_tx)                   nxt = m_rx_last ? O_TX : O_RX;
        else if (e_rx)                           nxt = O_RX;
        else if (e_tx)                           nxt = O_TX;
        else if (e_ahb)                          nxt = O_AHB;
        else                                     nxt = O_IDLE;
        if (!ahb_req || m_owner == O_AHB) m_stall = 0;
        else m_stall = (m_stall + 1 > MAX_WAIT) ? MAX_WAIT : m_stall + 1;
        if (nxt == O_AHB) m_wr = ahb_write;
        if (nxt == O_RX) m_rx_last = 1'b1;
        if (nxt == O_TX) m_rx_last = 1'b0;
        m_owner = nxt;
    endtask

    task automatic compare_model(input string tag);
        logic [8:0] act, exp;
        act = {rx_grant, tx_grant, ahb_grant, buf_clear, buf_we, buf_re, buf_sel, hready};
        exp[8]   = (m_owner == O_RX);
        exp[7]   = (m_owner == O_TX);
        exp[6]   = (m_owner == O_AHB);
        exp[5]   = (m_owner == O_CLR);
        exp[4]   = (m_owner == O_RX) || (m_owner == O_AHB && m_wr);
        exp[3]   = (m_owner == O_TX) || (m_owner == O_AHB && !m_wr);
        exp[2:1] = (m_owner <= O_AHB) ? 2'(m_owner) : 2'b00;
        exp[0]   = !ahb_req || (m_owner == O_AHB);
        check(tag, 32'(act), 32'(exp));
    endtask

    // One clock: drive inputs just after the rising edge, check at the falling edge.
    task automatic cycle(input logic c, input logic r, input logic t, input logic a, input logic w);
        @(posedge clk);
        #1;
        buf_clear_req = c;
        rx_req        = r;
        tx_req        = t;
        ahb_req       = a;
        ahb_write     = w;
        @(negedge clk);
        compare_model("model");
        model_step();
    endtask

    // Assert reset now, hold it through a rising edge, release on the falling edge.
    task automatic apply_reset(input logic r, input logic t, input logic a, input logic w);
        n_rst         = 1'b0;
        buf_clear_req = 1'b0;
        rx_req        = r;
        tx_req        = t;
        ahb_req       = a;
        ahb_write     = w;
        #1;
        check("rst_grants", {rx_grant, tx_grant, ahb_grant, buf_clear}, 4'b0000);
        check("rst_strobes", {buf_we, buf_re, buf_sel}, 4'b0000);
        check("rst_hready", hready, !a);
        @(negedge clk);
        n_rst = 1'b1;
        model_reset();
        compare_model("rst_model");
        model_step();
    endtask

    initial begin
        logic [1:0] prev;
        logic [2:0] seen;
        int         got_at;

        // Reset with AHB pending, then AHB read is granted one cycle later.
        apply_reset(1'b0, 1'b0, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        check("ahb_first_grant", {ahb_grant, hready, buf_re, buf_we, buf_sel}, 6'b1110_11);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // RX and TX held together: strict alternation.
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        prev = {rx_grant, tx_grant};
        for (int i = 0; i < 8; i++) begin
            cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
            check("alt_grant", {rx_grant, tx_grant}, {prev[0], prev[1]});
            check("alt_strobe", {buf_we, buf_re}, {prev[0], prev[1]});
            prev = {rx_grant, tx_grant};
        end

        // AHB against saturating USB traffic: granted exactly MAX_WAIT+1 cycles in.
        got_at = 10;
        for (int i = 0; i < 10; i++) begin
            cycle(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
            if (ahb_grant) begin
                got_at = i;
                break;
            end
            check("starve_hready", hready, 1'b0);
        end
        check("starve_latency", got_at, MAX_WAIT + 1);
        for (int i = 0; i < 8; i++) cycle(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);

        // Clear pulse with every requester pending.
        cycle(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        cycle(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
        check("clear_cycle", {buf_clear, buf_sel, buf_we, buf_re, rx_grant, tx_grant, ahb_grant},
              8'b1_00_00_000);
        seen = 3'b000;
        for (int i = 0; i < 8; i++) begin
            cycle(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
            seen |= {rx_grant, tx_grant, ahb_grant};
        end
        check("clear_resume", seen, 3'b111);

        // AHB write whose direction flips during the grant cycle.
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        check("wr_hold", {ahb_grant, buf_we, buf_re}, 3'b110);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Reset during a TX grant, then the first RX/TX tie goes to RX.
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("tx_before_rst", {tx_grant, buf_re}, 2'b11);
        apply_reset(1'b1, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        check("tie_after_rst", {rx_grant, tx_grant}, 2'b10);

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            cycle(1'($urandom_range(0, 99) < 8),
                  1'($urandom_range(0, 99) < 60),
                  1'($urandom_range(0, 99) < 60),
                  1'($urandom_range(0, 99) < 50),
                  1'($urandom_range(0, 1)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
